// File: rtl/faddsub_issue.sv
// faddsub_issue: issue/return wrapper around a fixed-latency, non-stallable
// fsub unit. Requests are credited against a small result FIFO so a result
// leaving the fsub pipeline always has a slot waiting for it.
module faddsub_issue #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fsub_op1,
  output logic [31:0]      fsub_op2,
  input  logic [31:0]      fsub_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  // wide enough for inflight + fcount without wrapping
  localparam int CW = $clog2(DEPTH + LAT + 1) + 1;

  logic [LAT-1:0]            vld_pipe;
  logic [LAT-1:0][TAG_W-1:0] tag_pipe;

  logic [31:0]      mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fcount;

  logic [CW-1:0] inflight, occupancy;
  logic          accept, push, pop;

  // fsub always subtracts, so an add is issued with op2's sign flipped
  assign fsub_op1 = in_a;
  assign fsub_op2 = in_op ? in_b : {~in_b[31], in_b[30:0]};

  assign accept = in_valid && in_ready;
  assign push   = vld_pipe[LAT-1];
  assign pop    = out_valid && out_ready;

  // count requests currently inside the fsub pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++)
      inflight = inflight + CW'(vld_pipe[i]);
  end

  // credit check: every in-flight request already owns a FIFO slot.
  // A pop this cycle is deliberately not credited, keeping out_ready off
  // the in_ready path.
  assign occupancy = inflight + CW'(fcount);
  assign in_ready  = occupancy < CW'(DEPTH);

  assign out_valid = (fcount != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_tag   = out_valid ? mem_tag[rd_ptr]  : '0;
  assign busy      = (inflight != '0) || out_valid;

  // valid/tag shadow of the fsub pipeline; advances every cycle since fsub cannot stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      tag_pipe[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // result storage; contents are only visible through out_valid gating, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= fsub_result;
      mem_tag[wr_ptr]  <= tag_pipe[LAT-1];
    end
  end

  // FIFO pointers and occupancy; push+pop together leaves fcount unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fcount <= fcount + (AW+1)'(1);
        2'b01:   fcount <= fcount - (AW+1)'(1);
        default: fcount <= fcount;
      endcase
    end
  end

  // the credit scheme makes a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (fcount == (AW+1)'(DEPTH))));

endmodule

// File: tb/tb_faddsub_issue.sv
// Bench for faddsub_issue: a stand-in fsub pipeline plus a transaction-level
// model (queue of accepted-but-not-consumed requests with accept timestamps).
module tb_faddsub_issue;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_op;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fsub_op1, fsub_op2, fsub_result;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  faddsub_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .fsub_op1(fsub_op1), .fsub_op2(fsub_op2), .fsub_result(fsub_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // single <-> real conversions (normals and zero; tiny results flush to zero)
  function automatic real s2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e < 11'd897)  return {d[63], 31'd0};
    if (e > 11'd1150) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  // expected result straight from the request: a+b or a-b
  function automatic logic [31:0] ref_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
    return r2s(op ? (s2r(a) - s2r(b)) : (s2r(a) + s2r(b)));
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
  endfunction

  // stand-in fsub: op1 - op2, result register LAT edges after presentation
  logic [31:0] fpipe [LAT];
  always @(posedge clk) begin
    fpipe[0] <= r2s(s2r(fsub_op1) - s2r(fsub_op2));
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fsub_result = fpipe[LAT-1];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               at;
  } ent_t;

  ent_t pend[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // model: credit free while fewer than DEPTH requests are outstanding;
  // head visible once LAT edges have passed since its accept edge
  function automatic logic m_rdy();
    return pend.size() < DEPTH;
  endfunction

  function automatic logic m_vld();
    if (pend.size() == 0) return 1'b0;
    return (pend[0].at + LAT) <= cyc_n;
  endfunction

  // drive one cycle from a negedge, update the model, return at the next negedge
  task automatic cyc(input logic v, input logic op, input logic [31:0] a, input logic [31:0] b,
                     input logic [TAG_W-1:0] tg, input logic ordy);
    logic rdy, vld;
    ent_t e;
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tg; out_ready = ordy;
    rdy = m_rdy();
    vld = m_vld();
    #1;
    if (reset) begin
      if (vld && ordy) pend.delete(0);
      if (v && rdy) begin
        e.tag = tg; e.data = ref_fn(a, b, op); e.at = cyc_n + 1;
        pend.push_back(e);
      end
    end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst busy got=%b exp=0", busy); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL rst out_data got=%h exp=0", out_data); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL rst out_tag got=%h exp=0", out_tag); end
    cyc(1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b1);
    reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_rel out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_add();
    cyc(1'b1, 1'b0, 32'h3F800000, 32'h40000000, TAG_W'(3), 1'b1);
    total++; if (fsub_op1 !== 32'h3F800000) begin bad++; $display("FAIL add op1 got=%h exp=3f800000", fsub_op1); end
    total++; if (fsub_op2 !== 32'hC0000000) begin bad++; $display("FAIL add op2 got=%h exp=c0000000", fsub_op2); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add first_accept busy got=%b exp=1", busy); end
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (out_valid !== (k == 4)) begin bad++; $display("FAIL add out_valid cyc%0d got=%b exp=%b", k, out_valid, k == 4); end
      if (k == 4) begin
        total++; if (out_data !== 32'h40400000) begin bad++; $display("FAIL add data got=%h exp=40400000", out_data); end
        total++; if (out_tag !== TAG_W'(3)) begin bad++; $display("FAIL add tag got=%0d exp=3", out_tag); end
      end
      cyc(1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b1);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL add busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_sub();
    cyc(1'b1, 1'b1, 32'h40400000, 32'h3F800000, TAG_W'(7), 1'b1);
    total++; if (fsub_op2 !== 32'h3F800000) begin bad++; $display("FAIL sub op2 got=%h exp=3f800000", fsub_op2); end
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (out_valid !== (k == 4)) begin bad++; $display("FAIL sub out_valid cyc%0d got=%b exp=%b", k, out_valid, k == 4); end
      if (k == 4) begin
        total++; if (out_data !== 32'h40000000) begin bad++; $display("FAIL sub data got=%h exp=40000000", out_data); end
        total++; if (out_tag !== TAG_W'(7)) begin bad++; $display("FAIL sub tag got=%0d exp=7", out_tag); end
      end
      cyc(1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ra [6], rb [6];
    logic ro [6];
    logic [TAG_W-1:0] seen [$];
    logic [31:0] hold_d;
    logic [TAG_W-1:0] hold_t;
    int nxt = 0;
    int ix;
    logic v;
    for (int i = 0; i < 6; i++) begin ra[i] = rnd_f(); rb[i] = rnd_f(); ro[i] = 1'($urandom); end
    hold_d = '0; hold_t = '0;
    // consumer stalled: only DEPTH requests may be accepted
    for (int c = 0; c < 8; c++) begin
      total++; if (in_ready !== (c < 4)) begin bad++; $display("FAIL bp in_ready c%0d got=%b exp=%b", c, in_ready, c < 4); end
      if (c >= 5) begin
        total++;
        if (out_data !== hold_d || out_tag !== hold_t) begin bad++; $display("FAIL bp stable got=%h/%h exp=%h/%h", out_tag, out_data, hold_t, hold_d); end
      end
      hold_d = out_data; hold_t = out_tag;
      v = nxt < 6; ix = v ? nxt : 0;
      if (v && m_rdy()) begin cyc(1'b1, ro[ix], ra[ix], rb[ix], TAG_W'(ix), 1'b0); nxt++; end
      else cyc(v, ro[ix], ra[ix], rb[ix], TAG_W'(ix), 1'b0);
    end
    total++; if (nxt !== 4) begin bad++; $display("FAIL bp accepted got=%0d exp=4", nxt); end
    // release the consumer
    for (int c = 0; c < 30; c++) begin
      total++; if (in_ready !== m_rdy()) begin bad++; $display("FAIL bp in_ready got=%b exp=%b", in_ready, m_rdy()); end
      total++; if (out_valid !== m_vld()) begin bad++; $display("FAIL bp out_valid got=%b exp=%b", out_valid, m_vld()); end
      if (m_vld()) begin
        total++;
        if (out_tag !== pend[0].tag || out_data !== pend[0].data) begin bad++; $display("FAIL bp head got=%h/%h exp=%h/%h", out_tag, out_data, pend[0].tag, pend[0].data); end
      end
      if (out_valid) seen.push_back(out_tag);
      v = nxt < 6; ix = v ? nxt : 0;
      if (v && m_rdy()) begin cyc(1'b1, ro[ix], ra[ix], rb[ix], TAG_W'(ix), 1'b1); nxt++; end
      else cyc(v, ro[ix], ra[ix], rb[ix], TAG_W'(ix), 1'b1);
    end
    total++; if (seen.size() !== 6) begin bad++; $display("FAIL bp count got=%0d exp=6", seen.size()); end
    for (int i = 0; i < seen.size() && i < 6; i++) begin
      total++; if (seen[i] !== TAG_W'(i)) begin bad++; $display("FAIL bp order idx%0d got=%0d exp=%0d", i, seen[i], i); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_full();
    int pops = 0;
    logic v;
    // fill the FIFO with the consumer stalled
    for (int c = 0; c < 8; c++)
      cyc(c < 4, 1'($urandom), rnd_f(), rnd_f(), TAG_W'(c + 8), 1'b0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full out_valid got=%b exp=1", out_valid); end
    // consumer always ready, producer always offering, then a drain tail
    for (int c = 0; c < 36; c++) begin
      total++; if (in_ready !== m_rdy()) begin bad++; $display("FAIL full in_ready got=%b exp=%b", in_ready, m_rdy()); end
      total++; if (out_valid !== m_vld()) begin bad++; $display("FAIL full out_valid got=%b exp=%b", out_valid, m_vld()); end
      if (m_vld()) begin
        total++;
        if (out_tag !== pend[0].tag || out_data !== pend[0].data) begin bad++; $display("FAIL full head got=%h/%h exp=%h/%h", out_tag, out_data, pend[0].tag, pend[0].data); end
      end
      total++; if (busy !== (pend.size() != 0)) begin bad++; $display("FAIL full busy got=%b exp=%b", busy, pend.size() != 0); end
      if (c < 4 && out_valid) pops++;
      v = c < 24;
      cyc(v, 1'($urandom), rnd_f(), rnd_f(), TAG_W'($urandom), 1'b1);
    end
    total++; if (pops !== 4) begin bad++; $display("FAIL full drain_rate got=%0d exp=4", pops); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, rnd_f(), rnd_f(), TAG_W'(21), 1'b1);
    cyc(1'b1, 1'b1, rnd_f(), rnd_f(), TAG_W'(22), 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b1);
    reset = 1'b0;
    pend.delete();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid busy got=%b exp=0", busy); end
    for (int c = 0; c < 2; c++) begin
      cyc(1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b1);
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid in_reset got=%b/%b exp=0/0", out_valid, busy); end
    end
    reset = 1'b1;
    for (int c = 0; c < 2 * LAT + 2; c++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid stale out_valid c%0d got=%b exp=0", c, out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid stale busy c%0d got=%b exp=0", c, busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid in_ready c%0d got=%b exp=1", c, in_ready); end
      cyc(1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b1);
    end
  endtask

  task automatic test_wrap();
    localparam int N = 3 * DEPTH + 1;
    logic [TAG_W-1:0] seen [$];
    int nxt = 0;
    logic v, ordy;
    for (int c = 0; c < 300; c++) begin
      if (nxt == N && pend.size() == 0) break;
      total++; if (in_ready !== m_rdy()) begin bad++; $display("FAIL wrap in_ready got=%b exp=%b", in_ready, m_rdy()); end
      total++; if (out_valid !== m_vld()) begin bad++; $display("FAIL wrap out_valid got=%b exp=%b", out_valid, m_vld()); end
      if (m_vld()) begin
        total++;
        if (out_tag !== pend[0].tag || out_data !== pend[0].data) begin bad++; $display("FAIL wrap head got=%h/%h exp=%h/%h", out_tag, out_data, pend[0].tag, pend[0].data); end
      end
      v = (nxt < N) && ($urandom_range(0, 3) != 0);
      ordy = 1'($urandom);
      if (out_valid && ordy) seen.push_back(out_tag);
      if (v && m_rdy()) begin cyc(1'b1, 1'($urandom), rnd_f(), rnd_f(), TAG_W'(nxt), ordy); nxt++; end
      else cyc(v, 1'($urandom), rnd_f(), rnd_f(), TAG_W'(nxt), ordy);
    end
    total++; if (seen.size() !== N) begin bad++; $display("FAIL wrap count got=%0d exp=%0d", seen.size(), N); end
    for (int i = 0; i < seen.size() && i < N; i++) begin
      total++; if (seen[i] !== TAG_W'(i)) begin bad++; $display("FAIL wrap order idx%0d got=%0d exp=%0d", i, seen[i], i); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap busy_after got=%b exp=0", busy); end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_full();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
